// File: rtl/dmem_if.sv
// MEM-stage data-memory interface: runs one req/ack access per aligned CPU
// request, stalls the pipeline until it completes, and aborts after TIMEOUT cycles.
module dmem_if #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        stall,
  output logic [31:0] cpu_rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic        aligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  // Size decode: byte lanes are big-endian, so offset 0 maps to be[3].
  always_comb begin
    aligned    = 1'b1;
    be_calc    = 4'b1111;
    wdata_calc = cpu_wdata;
    case (cpu_size)
      2'b00: begin
        be_calc    = 4'b1000 >> cpu_addr[1:0];
        wdata_calc = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        aligned    = ~cpu_addr[0];
        be_calc    = cpu_addr[1] ? 4'b0011 : 4'b1100;
        wdata_calc = {2{cpu_wdata[15:0]}};
      end
      default: begin
        aligned = (cpu_addr[1:0] == 2'b00);
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (aligned) begin
            stall       = 1'b1;
            state_d     = BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = cpu_wr;
            mem_addr_d  = {cpu_addr[31:2], 2'b00};
            mem_be_d    = be_calc;
            mem_wdata_d = wdata_calc;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          cnt_d     = 8'd0;
          if (!mem_we_q) begin
            cpu_rdata_d = mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Give up on an unresponsive memory; the load returns zero.
          state_d     = DONE;
          mem_req_d   = 1'b0;
          cnt_d       = 8'd0;
          cpu_rdata_d = 32'd0;
          bus_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      cpu_rdata_q <= 32'd0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_if.sv
// Directed bench for dmem_if: loads, stores, misalignment, timeout,
// reset during an access and back-to-back accesses.
module tb_dmem_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_wr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        stall;
  logic [31:0] cpu_rdata;
  logic        misalign;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic        cap_we;
  logic        cap_req0;
  logic        cap_req1;
  logic        hold_ok;

  dmem_if #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_size  (cpu_size),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .stall     (stall),
    .cpu_rdata (cpu_rdata),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Drives one access from an IDLE cycle (k=0); k>=1 are BUSY cycles and mem_ack
  // is raised at k==ack_k (-1 = never). Returns at the first unstalled cycle.
  task automatic run_access(input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int ack_k, input logic [31:0] rdata,
                            output int stall_cycles);
    stall_cycles = 0;
    hold_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        cpu_req = 1'b1; cpu_wr = wr; cpu_size = size;
        cpu_addr = addr; cpu_wdata = wdata;
      end
      mem_ack   = (k == ack_k);
      mem_rdata = (k == ack_k) ? rdata : 32'h0;
      #1;
      if (k == 0) cap_req0 = mem_req;
      if (k == 1) begin
        cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata;
        cap_we = mem_we; cap_req1 = mem_req;
      end
      if (k > 1 && stall &&
          ({mem_addr, mem_be, mem_wdata, mem_we, mem_req} !==
           {cap_addr, cap_be, cap_wdata, cap_we, 1'b1}))
        hold_ok = 1'b0;
      if (!stall) break;
      stall_cycles++;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mem_req, mem_we, misalign, bus_err, stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, misalign, bus_err, stall});
    end
    checks++;
    if ({mem_addr, mem_be, mem_wdata, cpu_rdata} !== 100'd0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h be=%b wdata=%h rdata=%h expected all zero",
               mem_addr, mem_be, mem_wdata, cpu_rdata);
    end
    reset = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_word_load();
    int sc;
    run_access(1'b0, 2'b10, 32'h100, 32'h0, 4, 32'hCAFEBABE, sc);
    checks++;
    if (sc !== 5) begin errors++; $display("FAIL wl_stall: got %0d cycles expected 5", sc); end
    checks++;
    if ({cap_req1, cap_we, cap_addr, cap_be} !== {1'b1, 1'b0, 32'h100, 4'b1111}) begin
      errors++;
      $display("FAIL wl_busy: got req=%b we=%b addr=%h be=%b expected 1 0 00000100 1111",
               cap_req1, cap_we, cap_addr, cap_be);
    end
    checks++;
    if ({cpu_rdata, mem_req, bus_err} !== {32'hCAFEBABE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wl_done: got rdata=%h req=%b err=%b expected cafebabe 0 0", cpu_rdata, mem_req, bus_err);
    end
    cpu_req = 1'b0;
    $display("word load 0x100: stall=%0d rdata=%h", sc, cpu_rdata);
  endtask

  task automatic test_store();
    int sc;
    run_access(1'b1, 2'b00, 32'h203, 32'h000000A5, 3, 32'hFFFFFFFF, sc);
    checks++;
    if ({cap_addr, cap_be, cap_wdata, cap_we} !== {32'h200, 4'b0001, 32'hA5A5A5A5, 1'b1}) begin
      errors++;
      $display("FAIL sb_bus: got addr=%h be=%b wdata=%h we=%b expected 00000200 0001 a5a5a5a5 1",
               cap_addr, cap_be, cap_wdata, cap_we);
    end
    checks++;
    if (hold_ok !== 1'b1 || sc !== 4) begin
      errors++;
      $display("FAIL sb_hold: got hold=%b stall=%0d expected 1 4", hold_ok, sc);
    end
    checks++;
    if (cpu_rdata !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL sb_rdata: got %h expected cafebabe", cpu_rdata);
    end
    cpu_req = 1'b0;
    $display("byte store 0x203: be=%b wdata=%h", cap_be, cap_wdata);
    run_access(1'b1, 2'b01, 32'h202, 32'hFFFF1234, 1, 32'h0, sc);
    checks++;
    if ({cap_addr, cap_be, cap_wdata} !== {32'h200, 4'b0011, 32'h12341234}) begin
      errors++;
      $display("FAIL sh_bus: got addr=%h be=%b wdata=%h expected 00000200 0011 12341234",
               cap_addr, cap_be, cap_wdata);
    end
    cpu_req = 1'b0;
    $display("half store 0x202: be=%b wdata=%h", cap_be, cap_wdata);
    run_access(1'b1, 2'b11, 32'h600, 32'h89ABCDEF, 1, 32'h0, sc);
    checks++;
    if ({cap_addr, cap_be, cap_wdata} !== {32'h600, 4'b1111, 32'h89ABCDEF}) begin
      errors++;
      $display("FAIL sw3_bus: got addr=%h be=%b wdata=%h expected 00000600 1111 89abcdef",
               cap_addr, cap_be, cap_wdata);
    end
    cpu_req = 1'b0;
    $display("size-3 store 0x600: be=%b wdata=%h", cap_be, cap_wdata);
  endtask

  task automatic test_half_load();
    int sc;
    run_access(1'b0, 2'b01, 32'h102, 32'h0, 1, 32'h12345678, sc);
    checks++;
    if ({cap_be, cap_addr} !== {4'b0011, 32'h100}) begin
      errors++;
      $display("FAIL hl_be: got be=%b addr=%h expected 0011 00000100", cap_be, cap_addr);
    end
    checks++;
    if (cpu_rdata !== 32'h12345678 || sc !== 2) begin
      errors++;
      $display("FAIL hl_done: got rdata=%h stall=%0d expected 12345678 2", cpu_rdata, sc);
    end
    cpu_req = 1'b0;
    $display("half load 0x102: be=%b rdata=%h", cap_be, cpu_rdata);
  endtask

  task automatic test_misalign();
    logic req_seen;
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'b01; cpu_addr = 32'h101;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL ma_stall: got %b expected 0", stall); end
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    checks++;
    if ({misalign, stall} !== 2'b10) begin
      errors++;
      $display("FAIL ma_pulse: got misalign=%b stall=%b expected 1 0", misalign, stall);
    end
    req_seen = mem_req;
    @(negedge clk); #1;
    req_seen = req_seen | mem_req;
    checks++;
    if (misalign !== 1'b0) begin errors++; $display("FAIL ma_clear: got %b expected 0", misalign); end
    @(negedge clk); #1;
    req_seen = req_seen | mem_req;
    checks++;
    if (req_seen !== 1'b0 || cpu_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL ma_noaccess: got req_seen=%b rdata=%h expected 0 12345678", req_seen, cpu_rdata);
    end
    $display("half load 0x101: misaligned, no access");
  endtask

  task automatic test_timeout();
    int sc;
    run_access(1'b0, 2'b10, 32'h300, 32'h0, -1, 32'h0, sc);
    checks++;
    if (sc !== 5) begin errors++; $display("FAIL to_stall: got %0d cycles expected 5", sc); end
    checks++;
    if ({bus_err, cpu_rdata, mem_req} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL to_done: got err=%b rdata=%h req=%b expected 1 00000000 0", bus_err, cpu_rdata, mem_req);
    end
    cpu_req = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({bus_err, stall, mem_req} !== 3'b000) begin
      errors++;
      $display("FAIL to_idle: got err=%b stall=%b req=%b expected 0 0 0", bus_err, stall, mem_req);
    end
    $display("timeout 0x300: bus_err pulse, rdata=%h", cpu_rdata);
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h400;
    @(negedge clk); #1;
    checks++;
    if ({mem_req, stall} !== 2'b11) begin
      errors++;
      $display("FAIL rb_busy: got req=%b stall=%b expected 1 1", mem_req, stall);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({mem_req, stall, mem_addr, mem_be} !== {1'b0, 1'b0, 32'h0, 4'h0}) begin
      errors++;
      $display("FAIL rb_abort: got req=%b stall=%b addr=%h be=%b expected 0 0 00000000 0000",
               mem_req, stall, mem_addr, mem_be);
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++;
    if ({cpu_rdata, mem_req, stall, bus_err} !== {32'h0, 3'b000}) begin
      errors++;
      $display("FAIL rb_lateack: got rdata=%h req=%b stall=%b err=%b expected 00000000 0 0 0",
               cpu_rdata, mem_req, stall, bus_err);
    end
    $display("reset during busy: access aborted, late ack ignored");
  endtask

  task automatic test_back_to_back();
    int sc;
    run_access(1'b0, 2'b10, 32'h500, 32'h0, 1, 32'h11111111, sc);
    checks++;
    if (cpu_rdata !== 32'h11111111 || sc !== 2) begin
      errors++;
      $display("FAIL bb_first: got rdata=%h stall=%0d expected 11111111 2", cpu_rdata, sc);
    end
    // cpu_req stays high through DONE; the next access must start fresh from IDLE.
    run_access(1'b0, 2'b10, 32'h504, 32'h0, 1, 32'h22222222, sc);
    checks++;
    if ({cap_req0, cap_addr} !== {1'b0, 32'h504}) begin
      errors++;
      $display("FAIL bb_restart: got req_at_idle=%b addr=%h expected 0 00000504", cap_req0, cap_addr);
    end
    checks++;
    if (cpu_rdata !== 32'h22222222 || sc !== 2) begin
      errors++;
      $display("FAIL bb_second: got rdata=%h stall=%0d expected 22222222 2", cpu_rdata, sc);
    end
    cpu_req = 1'b0;
    $display("back-to-back 0x500/0x504: rdata=%h", cpu_rdata);
  endtask

  initial begin
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'b00;
    cpu_addr = 32'h0; cpu_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_word_load();
    test_store();
    test_half_load();
    test_misalign();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
